// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the IF/MA requesters, the shared memory port and the arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          ma_req;
  logic          ma_we;
  logic [AW-1:0] ma_addr;
  logic [DW-1:0] ma_wdata;
  logic          ma_ack;
  logic [DW-1:0] ma_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          grant_ma;
  logic          timeout_err;

  modport slave (
    input  if_req, if_addr, ma_req, ma_we, ma_addr, ma_wdata, mem_rdata, mem_ready,
    output if_ack, if_rdata, ma_ack, ma_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           grant_ma, timeout_err
  );

  modport master (
    output if_req, if_addr, ma_req, ma_we, ma_addr, ma_wdata, mem_rdata, mem_ready,
    input  if_ack, if_rdata, ma_ack, ma_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           grant_ma, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter (IF vs MA) with registered handshake and access watchdog.
// Define MEM_ARB_RR_EN for round-robin tie breaking; default build gives MA fixed priority.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_port_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_e        state_q;
  logic [7:0]    wd_q, wd_d;
  logic          mem_en_q, mem_we_q, if_ack_q, ma_ack_q, grant_ma_q, terr_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q, if_rdata_q, ma_rdata_q, rsp_d;
  logic          pick_ma_d, done_d;

`ifdef MEM_ARB_RR_EN
  // Reset as if MA went last so the first tie goes to IF.
  logic last_ma_q;
  assign pick_ma_d = bus.ma_req & (~bus.if_req | ~last_ma_q);
`else
  assign pick_ma_d = bus.ma_req;
`endif

  assign wd_d   = wd_q + 8'd1;
  // mem_ready wins over a watchdog expiry in the same cycle.
  assign done_d = bus.mem_ready | (wd_d == TO);
  assign rsp_d  = bus.mem_ready ? bus.mem_rdata : {DW{1'b1}};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_ack_q    <= 1'b0;
      ma_ack_q    <= 1'b0;
      grant_ma_q  <= 1'b0;
      terr_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      ma_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
      last_ma_q   <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.if_req | bus.ma_req) begin
            grant_ma_q  <= pick_ma_d;
            mem_addr_q  <= pick_ma_d ? bus.ma_addr  : bus.if_addr;
            mem_we_q    <= pick_ma_d & bus.ma_we;
            mem_wdata_q <= pick_ma_d ? bus.ma_wdata : '0;
            mem_en_q    <= 1'b1;
            wd_q        <= '0;
            state_q     <= BUSY;
`ifdef MEM_ARB_RR_EN
            last_ma_q   <= pick_ma_d;
`endif
          end
        end
        BUSY: begin
          if (done_d) begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (!bus.mem_ready) terr_q <= 1'b1;
            if (grant_ma_q) begin
              ma_ack_q <= 1'b1;
              if (!mem_we_q) ma_rdata_q <= rsp_d;
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= rsp_d;
            end
            state_q <= RESP;
          end else begin
            wd_q <= wd_d;
          end
        end
        RESP: begin
          if_ack_q <= 1'b0;
          ma_ack_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.if_ack      = if_ack_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.ma_ack      = ma_ack_q;
  assign bus.ma_rdata    = ma_rdata_q;
  assign bus.grant_ma    = grant_ma_q;
  assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus tie, watchdog and reset sequences.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ma_req;
    logic        ma_we;
    logic [31:0] ma_addr;
    logic [31:0] ma_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_if_ack;
    logic        e_ma_ack;
    logic [31:0] e_if_rdata;
    logic [31:0] e_ma_rdata;
    logic        e_gnt;
    logic        e_terr;
  } vec_t;

  vec_t vt [14];

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.ma_req    = 1'b0;
    bus.ma_we     = 1'b0;
    bus.ma_addr   = '0;
    bus.ma_wdata  = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic chk_all(input string nm, input vec_t v);
    chk({nm, ".en"},     32'(bus.mem_en),      32'(v.e_en));
    chk({nm, ".we"},     32'(bus.mem_we),      32'(v.e_we));
    chk({nm, ".addr"},   bus.mem_addr,         v.e_addr);
    chk({nm, ".wdata"},  bus.mem_wdata,        v.e_wdata);
    chk({nm, ".if_ack"}, 32'(bus.if_ack),      32'(v.e_if_ack));
    chk({nm, ".ma_ack"}, 32'(bus.ma_ack),      32'(v.e_ma_ack));
    chk({nm, ".if_rd"},  bus.if_rdata,         v.e_if_rdata);
    chk({nm, ".ma_rd"},  bus.ma_rdata,         v.e_ma_rdata);
    chk({nm, ".gnt"},    32'(bus.grant_ma),    32'(v.e_gnt));
    chk({nm, ".terr"},   32'(bus.timeout_err), 32'(v.e_terr));
  endtask

  // Both requesters raise together; exp_ma names the expected winner.
  task automatic tie(input string nm, input logic exp_ma, input logic [31:0] rd);
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    bus.ma_req = 1'b1; bus.ma_we = 1'b0; bus.ma_addr = 32'h400; bus.ma_wdata = '0;
    cyc();
    chk({nm, ".gnt"},  32'(bus.grant_ma), 32'(exp_ma));
    chk({nm, ".en"},   32'(bus.mem_en),   32'd1);
    chk({nm, ".addr"}, bus.mem_addr,      exp_ma ? 32'h400 : 32'h300);
    bus.mem_ready = 1'b1; bus.mem_rdata = rd;
    cyc();
    chk({nm, ".ack"},  32'(exp_ma ? bus.ma_ack : bus.if_ack), 32'd1);
    chk({nm, ".rd"},   exp_ma ? bus.ma_rdata : bus.if_rdata, rd);
    drive_idle();
    cyc();
    cyc();
  endtask

  initial begin
    vt[0]  = '{1,32'h40,0,0,32'h0,32'h0,32'h0,0,         1,0,32'h40,32'h0,0,0,32'h0,32'h0,0,0};
    vt[1]  = '{1,32'h40,0,0,32'h0,32'h0,32'h20080005,1,  0,0,32'h40,32'h0,1,0,32'h20080005,32'h0,0,0};
    vt[2]  = '{1,32'h40,0,0,32'h0,32'h0,32'h0,0,         0,0,32'h40,32'h0,0,0,32'h20080005,32'h0,0,0};
    vt[3]  = '{0,32'h0,0,0,32'h0,32'h0,32'h77,1,         0,0,32'h40,32'h0,0,0,32'h20080005,32'h0,0,0};
    vt[4]  = '{0,32'h0,1,1,32'h100,32'hDEADBEEF,32'h0,0, 1,1,32'h100,32'hDEADBEEF,0,0,32'h20080005,32'h0,1,0};
    vt[5]  = vt[4];
    vt[6]  = vt[4];
    vt[7]  = '{0,32'h0,1,1,32'h100,32'hDEADBEEF,32'h12345678,1, 0,0,32'h100,32'hDEADBEEF,0,1,32'h20080005,32'h0,1,0};
    vt[8]  = '{0,32'h0,1,1,32'h100,32'hDEADBEEF,32'h0,1, 0,0,32'h100,32'hDEADBEEF,0,0,32'h20080005,32'h0,1,0};
    vt[9]  = '{0,32'h0,0,0,32'h0,32'h0,32'h0,1,          0,0,32'h100,32'hDEADBEEF,0,0,32'h20080005,32'h0,1,0};
    vt[10] = '{0,32'h0,1,0,32'h200,32'h5555,32'h0,0,     1,0,32'h200,32'h5555,0,0,32'h20080005,32'h0,1,0};
    vt[11] = '{0,32'h0,1,0,32'h200,32'h5555,32'hCAFE0001,1, 0,0,32'h200,32'h5555,0,1,32'h20080005,32'hCAFE0001,1,0};
    vt[12] = '{0,32'h0,1,0,32'h200,32'h5555,32'h0,0,     0,0,32'h200,32'h5555,0,0,32'h20080005,32'hCAFE0001,1,0};
    vt[13] = '{0,32'h0,0,0,32'h0,32'h0,32'h0,0,          0,0,32'h200,32'h5555,0,0,32'h20080005,32'hCAFE0001,1,0};

    drive_idle();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk_all("rst", '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0});

    for (int i = 0; i < 14; i++) begin
      bus.if_req    = vt[i].if_req;
      bus.if_addr   = vt[i].if_addr;
      bus.ma_req    = vt[i].ma_req;
      bus.ma_we     = vt[i].ma_we;
      bus.ma_addr   = vt[i].ma_addr;
      bus.ma_wdata  = vt[i].ma_wdata;
      bus.mem_rdata = vt[i].mem_rdata;
      bus.mem_ready = vt[i].mem_ready;
      cyc();
      chk_all($sformatf("v%0d", i), vt[i]);
    end

`ifdef MEM_ARB_RR_EN
    tie("tie0", 1'b0, 32'h1000);
    tie("tie1", 1'b1, 32'h1001);
    tie("tie2", 1'b0, 32'h1002);
`else
    tie("tie0", 1'b1, 32'h1000);
    tie("tie1", 1'b1, 32'h1001);
    tie("tie2", 1'b1, 32'h1002);
`endif

    // mem_ready lands on the last watchdog cycle: normal completion.
    bus.if_req = 1'b1; bus.if_addr = 32'h80;
    cyc();
    for (int i = 0; i < 14; i++) cyc();
    chk("edge.en", 32'(bus.mem_en), 32'd1);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hA5A5A5A5;
    cyc();
    chk("edge.ack",  32'(bus.if_ack),      32'd1);
    chk("edge.rd",   bus.if_rdata,         32'hA5A5A5A5);
    chk("edge.terr", 32'(bus.timeout_err), 32'd0);
    drive_idle();
    cyc();

    // No mem_ready at all: watchdog aborts after 15 BUSY cycles.
    begin
      int n;
      n = 0;
      bus.if_req = 1'b1; bus.if_addr = 32'h84;
      cyc();
      while (bus.mem_en === 1'b1 && n < 40) begin
        n++;
        cyc();
      end
      chk("to.len",  32'(n),                32'd15);
      chk("to.ack",  32'(bus.if_ack),       32'd1);
      chk("to.rd",   bus.if_rdata,          32'hFFFFFFFF);
      chk("to.terr", 32'(bus.timeout_err),  32'd1);
      drive_idle();
      cyc(); cyc(); cyc();
      chk("to.sticky", 32'(bus.timeout_err), 32'd1);
    end

    // Reset in the middle of a BUSY access drops it without an ack.
    bus.ma_req = 1'b1; bus.ma_we = 1'b1; bus.ma_addr = 32'h500; bus.ma_wdata = 32'h99;
    cyc();
    chk("mid.en", 32'(bus.mem_en), 32'd1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    drive_idle();
    chk_all("mid.rst", '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0});
    begin
      int acks;
      acks = 0;
      for (int i = 0; i < 3; i++) begin
        cyc();
        if (bus.if_ack === 1'b1 || bus.ma_ack === 1'b1 || bus.mem_en === 1'b1) acks++;
      end
      chk("mid.quiet", 32'(acks), 32'd0);
    end
`ifdef MEM_ARB_RR_EN
    tie("post", 1'b0, 32'h2000);
`else
    tie("post", 1'b1, 32'h2000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got=running exp=finished");
    $fatal(1);
  end
endmodule
